// File: rtl/jpeg_bit_packer.sv
// Entropy-coder output stage: packs variable-length fields MSB-first into bytes and pads the scan tail with 1s.
// Define JPEG_BYTE_STUFF_EN to insert a 0x00 byte after every emitted 0xFF.
module jpeg_bit_packer #(
  parameter int ACC_W    = 40,
  parameter int MAX_SIZE = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_SIZE-1:0] in_code,
  input  logic [4:0]          in_size,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_last,
  output logic                done
);
  typedef enum logic {S_PACK, S_FLUSH} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [5:0]         r_cnt;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_out_last;

  logic               w_stuff_pend;
  logic [4:0]         w_size;
  logic [MAX_SIZE-1:0] w_mask;
  logic [ACC_W-1:0]   w_field;
  logic [5:0]         w_shamt;
  logic               w_accept;
  logic               w_free;
  logic               w_flushing;
  logic [ACC_W-1:0]   w_acc_ins;
  logic [5:0]         w_cnt_ins;
  logic               w_load;
  logic [7:0]         w_byte;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [5:0]         w_cnt_nxt;
  logic               w_stuff_nxt;
  logic               w_last;
  logic               w_done;

  assign in_ready  = (r_state == S_PACK) && (r_cnt < 6'd8) && !w_stuff_pend;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = w_done;

  assign w_accept   = in_valid && in_ready;
  assign w_free     = !r_out_valid || out_ready;
  assign w_flushing = (r_state == S_FLUSH) || (w_accept && in_last);
  assign w_done     = (r_state == S_FLUSH) && (r_cnt == 6'd0) && !w_stuff_pend && w_free;

  // Insertion: the masked field lands directly below the valid bits, so bytes
  // completed by this field can be loaded in the same cycle.
  always_comb begin
    w_size    = (in_size > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : in_size;
    w_mask    = ~({MAX_SIZE{1'b1}} << w_size);
    w_field   = {{(ACC_W-MAX_SIZE){1'b0}}, in_code & w_mask};
    w_shamt   = 6'(ACC_W) - r_cnt - {1'b0, w_size};
    w_acc_ins = r_acc;
    w_cnt_ins = r_cnt;
    if (w_accept) begin
      w_acc_ins = r_acc | (w_field << w_shamt);
      w_cnt_ins = r_cnt + {1'b0, w_size};
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_byte      = 8'h00;
    w_acc_nxt   = w_acc_ins;
    w_cnt_nxt   = w_cnt_ins;
    w_stuff_nxt = w_stuff_pend;
    if (w_free) begin
      if (w_stuff_pend) begin
        w_load      = 1'b1;
        w_stuff_nxt = 1'b0;
      end else if (w_cnt_ins >= 6'd8) begin
        w_load    = 1'b1;
        w_byte    = w_acc_ins[ACC_W-1 -: 8];
        w_acc_nxt = w_acc_ins << 8;
        w_cnt_nxt = w_cnt_ins - 6'd8;
      end else if ((r_state == S_FLUSH) && (w_cnt_ins != 6'd0)) begin
        // Tail pad: unused low bits of the final partial byte become 1s.
        w_load    = 1'b1;
        w_byte    = w_acc_ins[ACC_W-1 -: 8] | (8'hFF >> w_cnt_ins[2:0]);
        w_acc_nxt = '0;
        w_cnt_nxt = 6'd0;
      end
`ifdef JPEG_BYTE_STUFF_EN
      if (w_load && (w_byte == 8'hFF))
        w_stuff_nxt = 1'b1;
`endif
    end
    w_last = w_load && w_flushing && (w_cnt_nxt == 6'd0) && !w_stuff_nxt;
  end

`ifdef JPEG_BYTE_STUFF_EN
  logic r_stuff_pend;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stuff_pend <= 1'b0;
    else        r_stuff_pend <= w_stuff_nxt;
  end
  assign w_stuff_pend = r_stuff_pend;
`else
  assign w_stuff_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PACK;
      r_acc       <= '0;
      r_cnt       <= 6'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_free) begin
        r_out_valid <= w_load;
        r_out_last  <= w_last;
        if (w_load) r_out_data <= w_byte;
      end
      if (r_state == S_PACK) begin
        if (w_accept && in_last) r_state <= S_FLUSH;
      end else if (w_done) begin
        r_state <= S_PACK;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Randomized bench for jpeg_bit_packer: a bit-queue reference model predicts the byte stream, last flags and done pulses.
module tb_jpeg_bit_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_code;
  logic [4:0]  in_size;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        done;

  jpeg_bit_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_size(in_size), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [26:0] code;
    logic [4:0]  size;
    logic        last;
  } fld_t;

  fld_t       src_q[$];
  logic [8:0] exp_q[$];
  bit         bitq[$];
  bit         flush_pend, hold_chk, lat_chk;
  logic [7:0] hold_data;
  logic       hold_last;
  int         vld_pct, rdy_mode;
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic fld_t mk(input logic [26:0] c, input logic [4:0] s, input logic l);
    return {c, s, l};
  endfunction

  task automatic emit(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
`ifdef JPEG_BYTE_STUFF_EN
    if (b == 8'hFF) exp_q.push_back(9'h000);
`endif
  endtask

  // Reference: a plain bit stream; every 8 bits form a byte, scan end pads with 1s.
  task automatic model_push(input fld_t f, output int nfull);
    int sz;
    logic [7:0] b;
    nfull = 0;
    sz = (f.size > 5'd27) ? 27 : int'(f.size);
    for (int i = sz - 1; i >= 0; i--) bitq.push_back(f.code[i]);
    while (bitq.size() >= 8) begin
      for (int k = 0; k < 8; k++) b = {b[6:0], bitq.pop_front()};
      emit(b);
      nfull++;
    end
    if (f.last) begin
      if (bitq.size() > 0) begin
        b = 8'hFF;
        for (int k = 7; bitq.size() > 0; k--) b[k] = bitq.pop_front();
        emit(b);
      end
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = exp_q[exp_q.size()-1] | 9'h100;
      flush_pend = 1;
    end
  endtask

  task automatic step();
    logic [8:0] e;
    logic exp_done;
    int nfull;
    bit was_empty;
    @(negedge clk);
    if (src_q.size() > 0 && (in_valid || $urandom_range(99) < vld_pct)) begin
      in_valid = 1'b1;
      {in_code, in_size, in_last} = src_q[0];
    end else begin
      in_valid = 1'b0;
    end
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
    #1;
    if (hold_chk) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_data);
      chk("hold_last", out_last, hold_last);
    end
    hold_chk  = out_valid && !out_ready;
    hold_data = out_data;
    hold_last = out_last;
    if (lat_chk) chk("latency", out_valid, 1);
    lat_chk = 0;
    if (out_valid && out_ready) begin
      chk("byte_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[7:0]);
        chk("out_last", out_last, e[8]);
      end
    end
    if (flush_pend) chk("in_ready_flush", in_ready, 0);
    exp_done = flush_pend && (exp_q.size() == 0);
    chk("done", done, exp_done);
    if (exp_done) flush_pend = 0;
    if (in_valid && in_ready) begin
      was_empty = (exp_q.size() == 0);
      model_push(src_q.pop_front(), nfull);
      lat_chk = was_empty && (nfull > 0);
    end
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || flush_pend) && k < lim) begin
      step();
      k++;
    end
    chk("drain_timeout", k >= lim, 0);
  endtask

  task automatic clear_model();
    src_q.delete(); exp_q.delete(); bitq.delete();
    flush_pend = 0; hold_chk = 0; lat_chk = 0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    fld_t f;
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_size = '0; in_last = 1'b0;
    out_ready = 1'b0; vld_pct = 100; rdy_mode = 0;
    clear_model();
    #12;
    chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Empty flush: no bytes, done the cycle after acceptance
    src_q.push_back(mk(27'h0, 5'd0, 1'b1));
    drain(50);
    // Two fields completing 0xBF
    src_q.push_back(mk(27'h5, 5'd3, 1'b0));
    src_q.push_back(mk(27'h1F, 5'd5, 1'b0));
    drain(50);
    // Single zero bit then pad -> 0x7F last
    src_q.push_back(mk(27'h0, 5'd1, 1'b1));
    drain(50);
    // 0xFF at scan end (stuffed when enabled)
    src_q.push_back(mk(27'h7FFFFFF, 5'd8, 1'b1));
    drain(50);
    // Multi-byte field under backpressure, then drain with a closing field
    rdy_mode = 2;
    src_q.push_back(mk(27'h7FFFFFF, 5'd27, 1'b0));
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
    end
    rdy_mode = 0;
    src_q.push_back(mk(27'h0, 5'd1, 1'b1));
    drain(100);
    // Saturated size (31 -> 27) with junk above the field
    src_q.push_back(mk(27'h5A5A5A5, 5'd31, 1'b1));
    drain(100);

    // Reset mid-scan discards pending bits
    rdy_mode = 2;
    src_q.push_back(mk(27'hFFFFF, 5'd20, 1'b0));
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs();
    clear_model();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    src_q.push_back(mk(27'hAB, 5'd8, 1'b1));
    drain(50);

    // Randomized traffic with random stalls on both sides
    vld_pct = 70;
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      f.code = 27'($urandom());
      f.size = 5'($urandom_range(31));
      f.last = (i == 299) || ($urandom_range(9) == 0);
      if (f.last && f.size == 5'd0) f.size = 5'd1;
      src_q.push_back(f);
    end
    drain(20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
